// File: rtl/uart_rx_param_if.sv
// Receive-side holding-register interface: word, status flags and the
// valid/ready handshake toward the register block.
interface uart_rx_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (output out, out_valid, frame_err, parity_err, overrun,
                  input  out_ready);
  modport slave  (input  out, out_valid, frame_err, parity_err, overrun,
                  output out_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, tick-driven mid-bit
// sampling, optional parity, one or two stop bits, holding register with
// valid/ready handshake and per-word status.
// Optional macro UART_RX_BREAK_EN adds break_det and post-break idle recovery.
module uart_rx_param #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int CNT_W  = 5
) (
  input  logic clk,
  input  logic arst_n,
  input  logic rst,
  input  logic tick,
  input  logic rx_en,
  input  logic parity_en,
  input  logic parity_odd,
  input  logic stop2,
  input  logic rx_data,
  output logic busy,
`ifdef UART_RX_BREAK_EN
  output logic break_det,
`endif
  uart_rx_param_if.master o
);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVS/2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OVS - 1);
  localparam logic [IW-1:0]    LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [IW-1:0]     bidx_q, bidx_d;
  logic [DATA_W-1:0] shift_q, shift_d, out_q, out_d;
  logic pen_q, pen_d, podd_q, podd_d, st2_q, st2_d;
  logic pmis_q, pmis_d, sbad_q, sbad_d, sec_q, sec_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic rxs, bad_now;
`ifdef UART_RX_BREAK_EN
  logic zero_q, zero_d, brk_q, brk_d, wait_q, wait_d;
`endif

  assign rxs          = sync_q[1];
  assign busy         = busy_q;
  assign o.out        = out_q;
  assign o.out_valid  = valid_q;
  assign o.frame_err  = ferr_q;
  assign o.parity_err = perr_q;
  assign o.overrun    = ovr_q;
`ifdef UART_RX_BREAK_EN
  assign break_det    = brk_q;
`endif

  // Next-state, datapath and handshake; synchronous clear folded in last.
  always_comb begin
    state_d = state_q;  sync_d = {sync_q[0], rx_data};
    tcnt_d  = tcnt_q;   bidx_d = bidx_q;  shift_d = shift_q;  out_d = out_q;
    pen_d   = pen_q;    podd_d = podd_q;  st2_d   = st2_q;
    pmis_d  = pmis_q;   sbad_d = sbad_q;  sec_d   = sec_q;
    valid_d = valid_q;  busy_d = busy_q;
    ferr_d  = ferr_q;   perr_d = perr_q;  ovr_d   = ovr_q;
    bad_now = sbad_q | ~rxs;
`ifdef UART_RX_BREAK_EN
    zero_d = zero_q;  brk_d = 1'b0;  wait_d = wait_q;
`endif
    // Consumer handshake; a commit below overrides the clear.
    if (valid_q && o.out_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (tick) begin
`ifdef UART_RX_BREAK_EN
          if (wait_q) begin
            // After a break, require OVS consecutive high ticks.
            if (!rxs)                tcnt_d = '0;
            else if (tcnt_q == FULL) begin wait_d = 1'b0; tcnt_d = '0; end
            else                     tcnt_d = tcnt_q + 1'b1;
          end else
`endif
          if (rx_en && !rxs) begin
            state_d = START;  tcnt_d = '0;  busy_d = 1'b1;
            pen_d = parity_en;  podd_d = parity_odd;  st2_d = stop2;
            pmis_d = 1'b0;  sbad_d = 1'b0;  sec_d = 1'b0;
`ifdef UART_RX_BREAK_EN
            zero_d = 1'b1;
`endif
          end
        end
      end
      START: if (tick) begin
        if (tcnt_q != HALF) tcnt_d = tcnt_q + 1'b1;
        else if (rxs) begin state_d = IDLE; busy_d = 1'b0; end
        else begin state_d = DATA; tcnt_d = '0; bidx_d = '0; end
      end
      DATA: if (tick) begin
        if (tcnt_q != FULL) tcnt_d = tcnt_q + 1'b1;
        else begin
          tcnt_d = '0;
          shift_d[bidx_q] = rxs;
`ifdef UART_RX_BREAK_EN
          zero_d = zero_q & ~rxs;
`endif
          if (bidx_q == LAST) state_d = pen_q ? PARITY : STOP;
          else                bidx_d  = bidx_q + 1'b1;
        end
      end
      PARITY: if (tick) begin
        if (tcnt_q != FULL) tcnt_d = tcnt_q + 1'b1;
        else begin
          tcnt_d  = '0;
          pmis_d  = ((^shift_q) ^ rxs) != podd_q;
          state_d = STOP;
`ifdef UART_RX_BREAK_EN
          zero_d = zero_q & ~rxs;
`endif
        end
      end
      STOP: if (tick) begin
        if (tcnt_q != FULL) tcnt_d = tcnt_q + 1'b1;
        else begin
          tcnt_d = '0;
          sbad_d = bad_now;
`ifdef UART_RX_BREAK_EN
          if (!sec_q) zero_d = zero_q & ~rxs;
`endif
          if (st2_q && !sec_q) sec_d = 1'b1;
          else begin
            // Commit: load holding register and status in one cycle.
            state_d = IDLE;     busy_d  = 1'b0;
            out_d   = shift_q;  ferr_d  = bad_now;
            perr_d  = pmis_q & pen_q;
            ovr_d   = valid_q & ~o.out_ready;
            valid_d = 1'b1;
`ifdef UART_RX_BREAK_EN
            if (zero_d) begin brk_d = 1'b1; wait_d = 1'b1; end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      state_d = IDLE;  sync_d = 2'b11;  tcnt_d = '0;  bidx_d = '0;
      shift_d = '0;    out_d  = '0;
      pen_d = 1'b0;  podd_d = 1'b0;  st2_d = 1'b0;
      pmis_d = 1'b0; sbad_d = 1'b0;  sec_d = 1'b0;
      valid_d = 1'b0; busy_d = 1'b0;
      ferr_d = 1'b0; perr_d = 1'b0;  ovr_d = 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_d = 1'b0; brk_d = 1'b0;   wait_d = 1'b0;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath, status and synchroniser registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= 2'b11;  tcnt_q <= '0;  bidx_q <= '0;
      shift_q <= '0;    out_q  <= '0;
      pen_q <= 1'b0;  podd_q <= 1'b0;  st2_q <= 1'b0;
      pmis_q <= 1'b0; sbad_q <= 1'b0;  sec_q <= 1'b0;
      valid_q <= 1'b0; busy_q <= 1'b0;
      ferr_q <= 1'b0; perr_q <= 1'b0;  ovr_q <= 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_q <= 1'b0; brk_q <= 1'b0;   wait_q <= 1'b0;
`endif
    end else begin
      sync_q <= sync_d;  tcnt_q <= tcnt_d;  bidx_q <= bidx_d;
      shift_q <= shift_d; out_q <= out_d;
      pen_q <= pen_d;   podd_q <= podd_d;  st2_q <= st2_d;
      pmis_q <= pmis_d; sbad_q <= sbad_d;  sec_q <= sec_d;
      valid_q <= valid_d; busy_q <= busy_d;
      ferr_q <= ferr_d; perr_q <= perr_d;  ovr_q <= ovr_d;
`ifdef UART_RX_BREAK_EN
      zero_q <= zero_d; brk_q <= brk_d;    wait_q <= wait_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: stimulus pushes hand-computed expected
// words; a monitor pops and compares at every commit (busy falling while
// out_valid is high).
module tb_uart_rx_param;
  localparam int DATA_W = 8;
  localparam int OVS    = 16;
  localparam int TDIV   = 4;            // clocks per tick
  localparam int BITCLK = OVS * TDIV;   // clocks per bit

  logic clk = 1'b0, arst_n = 1'b0, rst = 1'b0, tick = 1'b0;
  logic rx_en = 1'b1, parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic rx_data = 1'b1, busy;
`ifdef UART_RX_BREAK_EN
  logic break_det;
`endif

  uart_rx_param_if #(.DATA_W(DATA_W)) u_if ();

  uart_rx_param #(.DATA_W(DATA_W), .OVS(OVS), .CNT_W(5)) dut (
    .clk(clk), .arst_n(arst_n), .rst(rst), .tick(tick), .rx_en(rx_en),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx_data(rx_data), .busy(busy),
`ifdef UART_RX_BREAK_EN
    .break_det(break_det),
`endif
    .o(u_if)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (TDIV - 1) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  end

  typedef struct {
    logic [DATA_W-1:0] d;
    logic fe, pe, ov;
  } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic fe, input logic pe, input logic ov);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx_data = b;
    repeat (BITCLK) @(posedge clk);
    #1;
  endtask

  // Start, data LSB first, optional parity, one or two stop bits.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic pbit,
                            input logic s1, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    if (parity_en) send_bit(pbit);
    send_bit(s1);
    if (stop2) send_bit(s2);
    rx_data = 1'b1;
  endtask

  task automatic consume(input string name);
    @(posedge clk); #1 u_if.out_ready = 1'b1;
    @(posedge clk); #1 u_if.out_ready = 1'b0;
    check(name, 32'(u_if.out_valid), 0);
  endtask

  // Monitor: a commit is the cycle busy drops with out_valid high.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (arst_n && busy_prev && !busy && u_if.out_valid) begin
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL sb_unexpected: got word %0h expected none", u_if.out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data",       32'(u_if.out),        32'(e.d));
        check("sb_frame_err",  32'(u_if.frame_err),  32'(e.fe));
        check("sb_parity_err", 32'(u_if.parity_err), 32'(e.pe));
        check("sb_overrun",    32'(u_if.overrun),    32'(e.ov));
      end
    end
    busy_prev = busy;
  end

  initial begin
    bit seen;
    u_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out",        32'(u_if.out),        0);
    check("rst_out_valid",  32'(u_if.out_valid),  0);
    check("rst_busy",       32'(busy),            0);
    check("rst_frame_err",  32'(u_if.frame_err),  0);
    check("rst_parity_err", 32'(u_if.parity_err), 0);
    check("rst_overrun",    32'(u_if.overrun),    0);
    @(posedge clk); #1 arst_n = 1'b1;
    repeat (20) @(posedge clk); #1;

    // Basic frame, no parity, one stop.
    push(8'hA5, 0, 0, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check("a5_valid", 32'(u_if.out_valid), 1);
    check("a5_busy",  32'(busy), 0);
    consume("a5_consume");

    // Even parity: correct then wrong parity bit.
    parity_en = 1'b1; parity_odd = 1'b0;
    push(8'h3C, 0, 0, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    consume("par_ok_consume");
    push(8'h3C, 0, 1, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    consume("par_bad_consume");
    parity_en = 1'b0;

    // Two stop bits, second one low.
    stop2 = 1'b1;
    push(8'h81, 1, 0, 0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    consume("stop2_consume");
    stop2 = 1'b0;
    repeat (BITCLK) @(posedge clk); #1;

    // 3-tick low glitch: busy pulses, nothing committed.
    seen = 1'b0;
    rx_data = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 3 * TDIV) rx_data = 1'b1;
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen), 1);
    check("glitch_busy_end",  32'(busy), 0);
    check("glitch_no_valid",  32'(u_if.out_valid), 0);
    @(posedge clk); #1;

    // Overrun: two frames without consuming.
    push(8'h11, 0, 0, 0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    push(8'h22, 0, 0, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check("ovr_valid", 32'(u_if.out_valid), 1);
    consume("ovr_consume");

    // Async reset mid DATA, then a clean frame.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    arst_n = 1'b0;
    rx_data = 1'b1;
    @(negedge clk);
    check("arst_out",       32'(u_if.out),       0);
    check("arst_out_valid", 32'(u_if.out_valid), 0);
    check("arst_busy",      32'(busy),           0);
    check("arst_overrun",   32'(u_if.overrun),   0);
    @(posedge clk); #1 arst_n = 1'b1;
    repeat (2 * BITCLK) @(posedge clk); #1;
    push(8'h5A, 0, 0, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    consume("post_rst_consume");

    repeat (10) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
